// File: rtl/mvb_serializer_if.sv
// Word handshake between the frame/word scheduler (master) and the MVB serializer (slave).
interface mvb_serializer_if;
  localparam int unsigned WORD_W = 16;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mvb_serializer.sv
// MVB transmit serializer: shifts 16-bit words out MSB-first and appends a CRC-7 + even
// parity check byte after every data group (64 bits, or the whole frame when shorter).
module mvb_serializer #(
  parameter logic [6:0]  CRC_POLY   = 7'b1100101,
  parameter int unsigned GROUP_BITS = 64
) (
  input  logic                   clk_3M,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             frame_size,
  mvb_serializer_if.slave        word_if,
  output logic                   data_out,
  output logic                   tx_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   underrun,
  output logic                   size_error,
  output logic [8:0]             bit_counter
);
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CRC_W  = 7;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned BITS_W = 10;
  localparam int unsigned GRP_W  = 5;
  localparam int unsigned POS_W  = $clog2(GROUP_BITS + 8);
  localparam logic [2:0]  MAX_SIZE = 3'd4;

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_e;

  function automatic logic [BITS_W-1:0] data_bits(input logic [2:0] sz);
    return BITS_W'(WORD_W) << sz;
  endfunction

  function automatic logic [POS_W-1:0] group_bits(input logic [2:0] sz);
    logic [BITS_W-1:0] db;
    db = data_bits(sz);
    return (db < BITS_W'(GROUP_BITS)) ? POS_W'(db) : POS_W'(GROUP_BITS);
  endfunction

  function automatic logic [GRP_W-1:0] groups_left(input logic [2:0] sz);
    logic [BITS_W-1:0] db;
    db = data_bits(sz);
    if (db > BITS_W'(GROUP_BITS)) return GRP_W'(db / BITS_W'(GROUP_BITS) - BITS_W'(1));
    return '0;
  endfunction

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    return {c[CRC_W-2:0], 1'b0} ^ ((b ^ c[CRC_W-1]) ? CRC_POLY : CRC_W'(0));
  endfunction

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic                par_q, par_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [POS_W-1:0]    gbits_q, gbits_d;
  logic [GRP_W-1:0]    grp_q, grp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                data_out_q, data_out_d;
  logic                tx_en_q, tx_en_d;
  logic                busy_q;
  logic                in_ready_q, in_ready_d;
  logic                frame_done_q, frame_done_d;
  logic                size_error_q, size_error_d;
  logic                underrun_c;
  logic                chk_last_c;
  logic                fetch_next_c;

  // State holds what is on the line this cycle; outputs are registered from the next state.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    par_d        = par_q;
    pos_d        = pos_q;
    gbits_d      = gbits_q;
    grp_d        = grp_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    size_error_d = 1'b0;
    underrun_c   = 1'b0;
    chk_last_c   = (pos_q == gbits_q + POS_W'(7));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_size > MAX_SIZE) begin
            size_error_d = 1'b1;
          end else if (in_ready_q && word_if.in_valid) begin
            state_d = DATA;
            shift_d = word_if.in_data;
            crc_d   = '0;
            par_d   = 1'b0;
            pos_d   = '0;
            gbits_d = group_bits(frame_size);
            grp_d   = groups_left(frame_size);
            cnt_d   = '0;
          end
        end
      end
      DATA: begin
        crc_d   = crc_step(crc_q, shift_q[WORD_W-1]);
        par_d   = par_q ^ shift_q[WORD_W-1];
        shift_d = {shift_q[WORD_W-2:0], 1'b0};
        pos_d   = pos_q + POS_W'(1);
        cnt_d   = cnt_q + CNT_W'(1);
        if (in_ready_q) shift_d = word_if.in_data;
        if (pos_q == gbits_q - POS_W'(1)) state_d = CHECK;
      end
      CHECK: begin
        pos_d = pos_q + POS_W'(1);
        cnt_d = cnt_q + CNT_W'(1);
        if (!chk_last_c) begin
          // Emitted CRC bits also feed the parity so the last bit covers data + CRC.
          par_d = par_q ^ crc_q[CRC_W-1];
          crc_d = {crc_q[CRC_W-2:0], 1'b0};
        end else begin
          crc_d = '0;
          par_d = 1'b0;
          if (grp_q == '0) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            cnt_d        = cnt_q;
          end else begin
            state_d = DATA;
            shift_d = word_if.in_data;
            pos_d   = '0;
            grp_d   = grp_q - GRP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && in_ready_q && !word_if.in_valid) begin
      underrun_c   = 1'b1;
      state_d      = IDLE;
      crc_d        = '0;
      par_d        = 1'b0;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
    end

    // A fetch point is the last bit before a new word must start with no gap.
    fetch_next_c = ((state_d == DATA) && (pos_d[3:0] == 4'hF) && (pos_d != gbits_d - POS_W'(1))) ||
                   ((state_d == CHECK) && (pos_d == gbits_d + POS_W'(7)) && (grp_d != '0));
    in_ready_d   = (state_d == IDLE) || fetch_next_c;
    tx_en_d      = (state_d != IDLE);
    if (state_d == DATA)       data_out_d = shift_d[WORD_W-1];
    else if (state_d == CHECK) data_out_d = (pos_d == gbits_d + POS_W'(7)) ? par_d : crc_d[CRC_W-1];
    else                       data_out_d = 1'b0;
  end

  always_ff @(posedge clk_3M or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      crc_q        <= '0;
      par_q        <= 1'b0;
      pos_q        <= '0;
      gbits_q      <= '0;
      grp_q        <= '0;
      cnt_q        <= '0;
      data_out_q   <= 1'b0;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      size_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      par_q        <= par_d;
      pos_q        <= pos_d;
      gbits_q      <= gbits_d;
      grp_q        <= grp_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      tx_en_q      <= tx_en_d;
      busy_q       <= tx_en_d;
      in_ready_q   <= in_ready_d;
      frame_done_q <= frame_done_d;
      size_error_q <= size_error_d;
    end
  end

  assign word_if.in_ready = in_ready_q;
  assign data_out         = data_out_q;
  assign tx_en            = tx_en_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign size_error       = size_error_q;
  assign underrun         = underrun_c;
  assign bit_counter      = cnt_q;
endmodule

// File: tb/tb_mvb_serializer.sv
// Self-checking bench for mvb_serializer: size table, corner-case sequences and random frames
// compared against a polynomial-division CRC-7 + parity model of the line stream.
`timescale 1ns/1ps
module tb_mvb_serializer;
  localparam int HALF = 5;
  localparam logic [7:0] GEN = 8'b11100101;   // x^7 + x^6 + x^5 + x^2 + 1
  localparam int GB = 64;

  logic       clk_3M = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] frame_size;
  logic       data_out, tx_en, busy, frame_done, underrun, size_error;
  logic [8:0] bit_counter;

  mvb_serializer_if word_if();

  mvb_serializer dut (
    .clk_3M(clk_3M), .rst(rst), .start(start), .frame_size(frame_size), .word_if(word_if),
    .data_out(data_out), .tx_en(tx_en), .busy(busy), .frame_done(frame_done),
    .underrun(underrun), .size_error(size_error), .bit_counter(bit_counter)
  );

  always #HALF clk_3M = ~clk_3M;

  int checks = 0;
  int errors = 0;

  logic [15:0] wq[$];
  logic [15:0] fw[$];
  bit          exp_bits[$];
  int          exp_fetch[$];
  bit          last_got[$];
  int          last_fetch[$];

  typedef struct {
    logic [2:0] sz;
    int         exp_len;
    bit         legal;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Line stream of fw: data bits MSB-first, then per group remainder of M(x)*x^7 / G(x) and parity.
  function automatic void build_model();
    int nbits, gb, n;
    bit grp[$];
    bit r[$];
    bit p;
    logic [15:0] w;
    logic [7:0]  g8;
    g8 = GEN;
    nbits = fw.size() * 16;
    gb = (nbits < GB) ? nbits : GB;
    exp_bits.delete();
    exp_fetch.delete();
    for (int g = 0; g < nbits / gb; g++) begin
      grp.delete();
      for (int i = 0; i < gb; i++) begin
        n = g * gb + i;
        w = fw[n / 16];
        if (n % 16 == 0 && n > 0) exp_fetch.push_back(exp_bits.size() - 1);
        grp.push_back(w[15 - n % 16]);
        exp_bits.push_back(w[15 - n % 16]);
      end
      r = grp;
      for (int i = 0; i < 7; i++) r.push_back(1'b0);
      for (int i = 0; i < gb; i++)
        if (r[i]) for (int j = 0; j < 8; j++) r[i + j] = r[i + j] ^ g8[7 - j];
      p = 1'b0;
      foreach (grp[i]) p = p ^ grp[i];
      for (int i = 0; i < 7; i++) begin
        exp_bits.push_back(r[gb + i]);
        p = p ^ r[gb + i];
      end
      exp_bits.push_back(p);
    end
  endfunction

  task automatic run_frame(input logic [2:0] sz, input int abort_word, input bit pre_started,
                           input bit chain, input logic [2:0] chain_sz);
    int nwords, exp_len, k, und_k, widx, mism;
    bit got[$];
    int got_fetch[$];
    bit ended, cnt_ok, flag_ok;
    logic end_done, end_busy, end_dout;
    logic [8:0] end_cnt;
    nwords = 1 << sz;
    fw.delete();
    for (int i = 0; i < nwords; i++) fw.push_back(wq.pop_front());
    build_model();
    exp_len = exp_bits.size();
    if (abort_word > 0) begin
      exp_len = exp_fetch[abort_word - 1] + 1;
      while (exp_fetch.size() > abort_word) void'(exp_fetch.pop_back());
    end
    if (!pre_started) begin
      @(posedge clk_3M); #1;
      start = 1'b1; frame_size = sz; word_if.in_valid = 1'b1; word_if.in_data = fw[0];
      #1;
      check("idle_in_ready", word_if.in_ready, 1);
      check("idle_tx_en", tx_en, 0);
    end
    widx = 1; und_k = -1; ended = 0; cnt_ok = 1; flag_ok = 1;
    end_done = 0; end_busy = 1; end_dout = 1; end_cnt = '0;
    for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
      @(posedge clk_3M); #1;
      k = got.size();
      start = 1'b0;
      if (k == exp_len && chain) begin
        start = 1'b1; frame_size = chain_sz; word_if.in_valid = 1'b1; word_if.in_data = wq[0];
      end else if (k < exp_len && widx < nwords && widx - 1 < exp_fetch.size() &&
                   k == exp_fetch[widx - 1]) begin
        word_if.in_valid = (widx != abort_word);
        word_if.in_data  = fw[widx];
        if (widx != abort_word) widx++;
      end else begin
        word_if.in_valid = 1'($urandom_range(0, 1));
        word_if.in_data  = 16'($urandom);
        if (k < exp_len && $urandom_range(0, 7) == 0) begin
          start = 1'b1; frame_size = 3'($urandom);
        end
      end
      #1;
      if (tx_en) begin
        if (bit_counter != 9'(k)) cnt_ok = 0;
        if (!busy || frame_done || size_error) flag_ok = 0;
        if (underrun) und_k = k;
        if (word_if.in_ready) got_fetch.push_back(k);
        got.push_back(data_out);
      end else if (k > 0) begin
        ended = 1; end_done = frame_done; end_busy = busy; end_dout = data_out; end_cnt = bit_counter;
      end
    end
    check("frame_ended", ended, 1);
    check("frame_len", got.size(), exp_len);
    mism = -1;
    for (int i = 0; i < got.size() && i < exp_len; i++)
      if (mism < 0 && got[i] != exp_bits[i]) mism = i;
    check("stream_first_diff_idx", mism, -1);
    check("fetch_count", got_fetch.size(), exp_fetch.size());
    mism = -1;
    for (int i = 0; i < got_fetch.size() && i < exp_fetch.size(); i++)
      if (mism < 0 && got_fetch[i] != exp_fetch[i]) mism = i;
    check("fetch_first_diff_idx", mism, -1);
    check("bit_counter_track", cnt_ok, 1);
    check("flags_in_frame", flag_ok, 1);
    check("underrun_pos", und_k, (abort_word > 0) ? exp_len - 1 : -1);
    check("frame_done_at_end", end_done, (abort_word > 0) ? 0 : 1);
    check("busy_at_end", end_busy, 0);
    check("data_out_at_end", end_dout, 0);
    if (abort_word <= 0) check("bit_counter_hold", end_cnt, exp_len - 1);
    last_got = got;
    last_fetch = got_fetch;
  endtask

  task automatic illegal_start(input logic [2:0] sz);
    @(posedge clk_3M); #1;
    start = 1'b1; frame_size = sz; word_if.in_valid = 1'b1; word_if.in_data = 16'($urandom);
    @(posedge clk_3M); #1;
    start = 1'b0;
    #1;
    check("size_error_pulse", size_error, 1);
    check("size_error_busy", busy, 0);
    check("size_error_tx_en", tx_en, 0);
    check("size_error_in_ready", word_if.in_ready, 1);
    @(posedge clk_3M); #2;
    check("size_error_one_cycle", size_error, 0);
    check("size_error_busy_after", busy, 0);
  endtask

  initial begin
    logic [2:0] cur_sz, nxt_sz;
    bit pre, ch, found;
    int ab, ones;

    rst = 1'b0; start = 1'b0; frame_size = '0;
    word_if.in_valid = 1'b0; word_if.in_data = '0;
    repeat (3) @(posedge clk_3M);
    #1;
    check("rst_tx_en", tx_en, 0);
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_bit_counter", bit_counter, 0);
    check("rst_in_ready", word_if.in_ready, 0);
    check("rst_flags", {frame_done, underrun, size_error}, 0);
    rst = 1'b1;

    // start without a valid word is ignored
    @(posedge clk_3M); #1;
    start = 1'b1; frame_size = 3'd0; word_if.in_valid = 1'b0;
    @(posedge clk_3M); #1;
    start = 1'b0;
    @(posedge clk_3M); #1;
    check("start_no_valid_busy", busy, 0);
    check("start_no_valid_tx_en", tx_en, 0);

    vecs[0] = '{3'd0, 24, 1'b1};
    vecs[1] = '{3'd1, 40, 1'b1};
    vecs[2] = '{3'd2, 72, 1'b1};
    vecs[3] = '{3'd3, 144, 1'b1};
    vecs[4] = '{3'd4, 288, 1'b1};
    vecs[5] = '{3'd5, 0, 1'b0};
    vecs[6] = '{3'd6, 0, 1'b0};
    vecs[7] = '{3'd7, 0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].legal) begin
        wq.delete();
        for (int w = 0; w < (1 << vecs[i].sz); w++) wq.push_back(16'(w * 16'h1111 + i));
        run_frame(vecs[i].sz, -1, 0, 0, 3'd0);
        check("table_tx_len", last_got.size(), vecs[i].exp_len);
      end else begin
        illegal_start(vecs[i].sz);
      end
    end

    // all-zero 16-bit frame: 24 zero bits including an 8'h00 check byte
    wq.delete(); wq.push_back(16'h0000);
    run_frame(3'd0, -1, 0, 0, 3'd0);
    ones = 0;
    foreach (last_got[i]) if (last_got[i]) ones++;
    check("zero_frame_ones", ones, 0);
    check("zero_frame_fetches", last_fetch.size(), 0);

    // 64-bit frame with fetches at 15, 31, 47
    wq.delete();
    wq.push_back(16'hA5A5); wq.push_back(16'h5A5A); wq.push_back(16'hFFFF); wq.push_back(16'h0001);
    run_frame(3'd2, -1, 0, 0, 3'd0);
    check("f64_fetch_n", last_fetch.size(), 3);
    if (last_fetch.size() == 3) begin
      check("f64_fetch0", last_fetch[0], 15);
      check("f64_fetch1", last_fetch[1], 31);
      check("f64_fetch2", last_fetch[2], 47);
    end

    // 128-bit frame starved at the group-boundary fetch (bit 71), then a clean frame
    wq.delete();
    for (int w = 0; w < 8; w++) wq.push_back(16'($urandom));
    run_frame(3'd3, 4, 0, 0, 3'd0);
    for (int w = 0; w < 4; w++) wq.push_back(16'($urandom));
    run_frame(3'd2, -1, 0, 0, 3'd0);

    // asynchronous reset at bit 50 of a 72-bit frame
    found = 0;
    @(posedge clk_3M); #1;
    start = 1'b1; frame_size = 3'd2; word_if.in_valid = 1'b1; word_if.in_data = 16'hBEEF;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk_3M); #1;
      start = 1'b0; word_if.in_valid = 1'b1; word_if.in_data = 16'($urandom);
      #1;
      if (tx_en && bit_counter == 9'd50) found = 1;
    end
    check("reached_bit50", found, 1);
    rst = 1'b0;
    #1;
    check("arst_tx_en", tx_en, 0);
    check("arst_busy", busy, 0);
    check("arst_data_out", data_out, 0);
    check("arst_bit_counter", bit_counter, 0);
    check("arst_in_ready", word_if.in_ready, 0);
    @(posedge clk_3M); #1;
    rst = 1'b1;
    wq.delete();
    for (int w = 0; w < 4; w++) wq.push_back(16'($urandom));
    run_frame(3'd2, -1, 0, 0, 3'd0);

    // back-to-back: start in the frame_done cycle
    wq.delete();
    for (int w = 0; w < 4; w++) wq.push_back(16'($urandom));
    wq.push_back(16'h8001);
    run_frame(3'd2, -1, 0, 1, 3'd0);
    for (int w = 0; w < 16; w++) wq.push_back(16'(w));
    run_frame(3'd0, -1, 1, 1, 3'd4);
    run_frame(3'd4, -1, 1, 0, 3'd0);

    // random frames, random aborts and chaining
    pre = 0;
    cur_sz = 3'($urandom_range(0, 4));
    wq.delete();
    for (int it = 0; it < 12; it++) begin
      nxt_sz = 3'($urandom_range(0, 4));
      ab = ((1 << cur_sz) > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, (1 << cur_sz) - 1) : -1;
      ch = (ab < 0) && ($urandom_range(0, 1) == 1) && (it < 11);
      if (!pre) for (int w = 0; w < (1 << cur_sz); w++) wq.push_back(16'($urandom));
      if (ch) for (int w = 0; w < (1 << nxt_sz); w++) wq.push_back(16'($urandom));
      run_frame(cur_sz, ab, pre, ch, nxt_sz);
      pre = ch;
      cur_sz = nxt_sz;
    end

    repeat (2) @(posedge clk_3M);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
